// File: rtl/sha256_pkg.sv
// Shared types, widths and the SHA-256 small-sigma functions used by the
// message schedule.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 512;
  localparam int WIN_DEPTH = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t sha256_s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sha256_s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_expand.sv
// Combinational next-word generator for the 16-word schedule window.
module sha256_msg_expand
  import sha256_pkg::*;
(
  input  word_t w14,
  input  word_t w9,
  input  word_t w1,
  input  word_t w0,
  output word_t w_new
);

  // W(t+16) = s1(W(t+14)) + W(t+9) + s0(W(t+1)) + W(t), wrapping at 32 bits
  always_comb begin
    w_new = sha256_s1(w14) + w9 + sha256_s0(w1) + w0;
  end

endmodule

// File: rtl/message_schedule.sv
// SHA-256 message schedule: takes 512-bit padded blocks and streams
// W0..W(ROUNDS-1) one word per handshake using a 16-word sliding window.
// Optional MESSAGE_SCHEDULE_PREFETCH_EN adds a one-block prefetch buffer so
// consecutive blocks stream without a bubble.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high and en is high. A source holding valid keeps its payload stable
// until the transfer; data_out* stay stable while data_out_valid & !ready.
module message_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic                 sync_rst,
  input  logic [BLOCK_W-1:0]   data_in,
  input  logic                 data_in_last,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [WORD_W-1:0]    data_out,
  output logic [5:0]           data_out_index,
  output logic                 data_out_blk_end,
  output logic                 data_out_last,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output state_t               dbg_state
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state_q, state_d;
  word_t       win_q [WIN_DEPTH];
  word_t       win_d [WIN_DEPTH];
  logic [5:0]  t_q, t_d;
  logic        last_q, last_d;
  word_t       w_new;

  logic        in_fire;
  logic        out_fire;
  logic        end_fire;

`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic               buf_last_q, buf_last_d;
  logic               buf_full_q, buf_full_d;
`endif

  assign in_fire  = en & data_in_valid & data_in_ready;
  assign out_fire = en & data_out_valid & data_out_ready;
  assign end_fire = out_fire & (t_q == LAST_T);

  sha256_msg_expand u_expand (
    .w14  (win_q[14]),
    .w9   (win_q[9]),
    .w1   (win_q[1]),
    .w0   (win_q[0]),
    .w_new(w_new)
  );

  // Output decode: every output is a function of registered state only
  always_comb begin
    data_out_valid   = (state_q == EXPAND);
    data_out         = win_q[0];
    data_out_index   = t_q;
    data_out_blk_end = (state_q == EXPAND) && (t_q == LAST_T);
    data_out_last    = (state_q == EXPAND) && (t_q == LAST_T) && last_q;
    dbg_state        = state_q;
`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
    data_in_ready    = !buf_full_q;
`else
    data_in_ready    = (state_q == IDLE);
`endif
  end

  // Next-state: leave IDLE on a block, return only when no follow-on block exists
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_fire) state_d = EXPAND;
      end
      EXPAND: begin
        if (end_fire) begin
`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
          if (!buf_full_q && !in_fire) state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window / counter / buffer datapath: load, shift-and-expand, or hold
  always_comb begin
    logic               load_now;
    logic [BLOCK_W-1:0] load_blk;
    logic               load_last;

    win_d     = win_q;
    t_d       = t_q;
    last_d    = last_q;
    load_now  = 1'b0;
    load_blk  = data_in;
    load_last = data_in_last;
`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
    buf_d      = buf_q;
    buf_last_d = buf_last_q;
    buf_full_d = buf_full_q;
`endif

    if (state_q == IDLE) begin
      if (in_fire) load_now = 1'b1;
    end else if (out_fire) begin
      for (int k = 0; k < WIN_DEPTH - 1; k++) win_d[k] = win_q[k+1];
      win_d[WIN_DEPTH-1] = w_new;
      if (end_fire) begin
        t_d = 6'd0;
`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
        if (buf_full_q) begin
          load_now   = 1'b1;
          load_blk   = buf_q;
          load_last  = buf_last_q;
          buf_full_d = 1'b0;
        end else if (in_fire) begin
          load_now = 1'b1;
        end
`endif
      end else begin
        t_d = t_q + 6'd1;
      end
    end

`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
    // A block arriving mid-stream parks in the buffer; at the block end it goes straight to the window
    if (state_q == EXPAND && in_fire && !end_fire) begin
      buf_d      = data_in;
      buf_last_d = data_in_last;
      buf_full_d = 1'b1;
    end
`endif

    if (load_now) begin
      for (int k = 0; k < WIN_DEPTH; k++)
        win_d[k] = load_blk[BLOCK_W-1-WORD_W*k -: WORD_W];
      t_d    = 6'd0;
      last_d = load_last;
    end
  end

  // State register: async nrst, sync_rst has the same effect, en freezes everything
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      t_q     <= 6'd0;
      last_q  <= 1'b0;
      for (int k = 0; k < WIN_DEPTH; k++) win_q[k] <= '0;
`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
      buf_q      <= '0;
      buf_last_q <= 1'b0;
      buf_full_q <= 1'b0;
`endif
    end else if (sync_rst) begin
      state_q <= IDLE;
      t_q     <= 6'd0;
      last_q  <= 1'b0;
      for (int k = 0; k < WIN_DEPTH; k++) win_q[k] <= '0;
`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
      buf_q      <= '0;
      buf_last_q <= 1'b0;
      buf_full_q <= 1'b0;
`endif
    end else if (en) begin
      state_q <= state_d;
      t_q     <= t_d;
      last_q  <= last_d;
      for (int k = 0; k < WIN_DEPTH; k++) win_q[k] <= win_d[k];
`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
      buf_q      <= buf_d;
      buf_last_q <= buf_last_d;
      buf_full_q <= buf_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_message_schedule.sv
// Self-checking bench for message_schedule: golden full-array schedule model,
// scoreboard queue of expected words, table of known "abc" words, and
// hand-written sequences for stall, back-to-back, sync_rst, en and ROUNDS=16.
module tb_message_schedule;
  import sha256_pkg::*;

  localparam int R = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nrst, en, sync_rst;
  logic [511:0] data_in;
  logic         data_in_last, data_in_valid, data_in_ready;
  logic [31:0]  data_out;
  logic [5:0]   data_out_index;
  logic         data_out_blk_end, data_out_last, data_out_valid, data_out_ready;
  state_t       dbg_state;

  logic [511:0] b_data_in;
  logic         b_data_in_last, b_data_in_valid, b_data_in_ready;
  logic [31:0]  b_data_out;
  logic [5:0]   b_data_out_index;
  logic         b_data_out_blk_end, b_data_out_last, b_data_out_valid;
  state_t       b_dbg_state;

  message_schedule #(.ROUNDS(R)) dut (
    .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
    .data_in(data_in), .data_in_last(data_in_last),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_index(data_out_index),
    .data_out_blk_end(data_out_blk_end), .data_out_last(data_out_last),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .dbg_state(dbg_state)
  );

  message_schedule #(.ROUNDS(16)) dut16 (
    .clk(clk), .nrst(nrst), .en(1'b1), .sync_rst(1'b0),
    .data_in(b_data_in), .data_in_last(b_data_in_last),
    .data_in_valid(b_data_in_valid), .data_in_ready(b_data_in_ready),
    .data_out(b_data_out), .data_out_index(b_data_out_index),
    .data_out_blk_end(b_data_out_blk_end), .data_out_last(b_data_out_last),
    .data_out_valid(b_data_out_valid), .data_out_ready(1'b1),
    .dbg_state(b_dbg_state)
  );

  typedef struct {
    int          idx;
    logic [31:0] w;
  } vec_t;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          cyc = 0;
  logic [39:0] exp_q[$];
  logic [31:0] cap_w[64];
  logic [31:0] ref_w[64];
  int          last_gap;
  int          end_cyc;
  bit          seen_end;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Reference schedule computed over the full 64-entry array
  function automatic void golden(input logic [511:0] b, output logic [31:0] w[64]);
    logic [31:0] g0, g1;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      g0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      g1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = g1 + w[i-7] + g0 + w[i-16];
    end
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[32*k +: 32] = $urandom();
    return b;
  endfunction

  // Pops one expected word per output transfer; checks hold while stalled
  task automatic monitor();
    logic [39:0] e;
    logic        st_prev;
    logic [31:0] pd;
    logic [5:0]  pi;
    st_prev = 1'b0;
    pd = '0;
    pi = '0;
    forever begin
      @(negedge clk);
      if (!nrst || sync_rst) begin
        st_prev  = 1'b0;
        seen_end = 1'b0;
      end else begin
        if (st_prev)
          check(data_out == pd && data_out_index == pi && data_out_valid, "stall_hold",
                64'({data_out_valid, data_out_index, data_out}), 64'({1'b1, pi, pd}));
        if (en && data_out_valid && data_out_ready) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_word", 64'({data_out_index, data_out}), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check({data_out, data_out_index, data_out_blk_end, data_out_last} == e, "word",
                  64'({data_out, data_out_index, data_out_blk_end, data_out_last}), 64'(e));
          end
          cap_w[data_out_index] = data_out;
          if (data_out_index == 6'd0 && seen_end) begin
            last_gap = cyc - end_cyc - 1;
            seen_end = 1'b0;
          end
          if (data_out_blk_end) begin
            end_cyc  = cyc;
            seen_end = 1'b1;
          end
          st_prev = 1'b0;
        end else begin
          st_prev = data_out_valid;
          pd = data_out;
          pi = data_out_index;
        end
      end
    end
  endtask

  task automatic send_block(input logic [511:0] blk, input logic lst, output bit ok, output logic busy);
    logic [31:0] w[64];
    data_in       = blk;
    data_in_last  = lst;
    data_in_valid = 1'b1;
    ok   = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (data_in_ready && en && !sync_rst) begin
        ok   = 1'b1;
        busy = data_out_valid;
        break;
      end
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    check(ok, "block_accept", 64'(ok), 64'd1);
    if (ok) begin
      golden(blk, w);
      for (int t = 0; t < R; t++)
        exp_q.push_back({w[t], 6'(t), t == R - 1, lst && (t == R - 1)});
    end
  endtask

  task automatic drain(input bit rnd, input int max, input string name);
    int i;
    for (i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      data_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (exp_q.size() == 0 && !data_out_valid) break;
    end
    data_out_ready = 1'b1;
    check(i < max, name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_index(input int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (data_out_valid && data_out_index == 6'(idx)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    vec_t         abc_tab[6];
    logic [511:0] blk, b1, b2;
    bit           ok;
    logic         busy;
    int           mm, nw;
    bit           exp_busy;
    int           exp_gap;

    abc_tab[0] = '{0,  32'h61626380};
    abc_tab[1] = '{1,  32'h00000000};
    abc_tab[2] = '{14, 32'h00000000};
    abc_tab[3] = '{15, 32'h00000018};
    abc_tab[4] = '{16, 32'h61626380};
    abc_tab[5] = '{17, 32'h000F0000};

`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
    exp_busy = 1'b1;
    exp_gap  = 0;
`else
    exp_busy = 1'b0;
    exp_gap  = 1;
`endif

    nrst = 1'b0; en = 1'b1; sync_rst = 1'b0;
    data_in = '0; data_in_last = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b1;
    b_data_in = '0; b_data_in_last = 1'b0; b_data_in_valid = 1'b0;
    last_gap = -1; end_cyc = 0; seen_end = 1'b0;

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check(data_in_ready && !data_out_valid && data_out == 32'd0 && data_out_index == 6'd0 &&
          !data_out_blk_end && !data_out_last, "reset_state",
          64'({data_in_ready, data_out_valid, data_out_blk_end, data_out_last, data_out_index, data_out}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0}));
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // "abc" block with ready held high
    blk = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    send_block(blk, 1'b1, ok, busy);
    drain(1'b0, 300, "abc_drain");
    for (int i = 0; i < 6; i++)
      check(cap_w[abc_tab[i].idx] == abc_tab[i].w, "abc_table", 64'(cap_w[abc_tab[i].idx]), 64'(abc_tab[i].w));
    for (int i = 0; i < 64; i++) ref_w[i] = cap_w[i];

    // Same block under random output stalls
    for (int i = 0; i < 64; i++) cap_w[i] = 32'hdeadbeef;
    send_block(blk, 1'b1, ok, busy);
    drain(1'b1, 3000, "stall_drain");
    mm = 0;
    for (int i = 0; i < 64; i++) if (cap_w[i] != ref_w[i]) mm++;
    check(mm == 0, "stall_vs_ready_run", 64'(mm), 64'd0);

    // Two back-to-back blocks with valid held high
    b1 = rand_block();
    b2 = rand_block();
    last_gap = -1;
    send_block(b1, 1'b0, ok, busy);
    send_block(b2, 1'b1, ok, busy);
    check(busy == exp_busy, "second_accept_during_stream", 64'(busy), 64'(exp_busy));
    drain(1'b0, 400, "b2b_drain");
    check(last_gap == exp_gap, "b2b_gap", 64'(last_gap), 64'(exp_gap));

    // sync_rst pulsed while t=20 is presented
    send_block(rand_block(), 1'b0, ok, busy);
    wait_index(20, ok);
    check(ok, "reach_t20", 64'(ok), 64'd1);
    sync_rst = 1'b1;
    @(posedge clk);
    #1;
    sync_rst = 1'b0;
    exp_q.delete();
    check(!data_out_valid && data_in_ready && data_out_index == 6'd0 && data_out == 32'd0 &&
          !data_out_blk_end && !data_out_last, "after_sync_rst",
          64'({data_out_valid, data_in_ready, data_out_index, data_out}),
          64'({1'b0, 1'b1, 6'd0, 32'd0}));
    send_block('0, 1'b1, ok, busy);
    drain(1'b0, 300, "zero_drain");

    // en low for 5 cycles while t=30 is presented
    send_block(rand_block(), 1'b1, ok, busy);
    wait_index(30, ok);
    check(ok, "reach_t30", 64'(ok), 64'd1);
    en = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check(data_out_valid && data_out_index == 6'd30, "en_freeze",
            64'({data_out_valid, data_out_index}), 64'({1'b1, 6'd30}));
    end
    en = 1'b1;
    drain(1'b0, 300, "en_drain");

    // ROUNDS=16 instance: words equal the block, blk_end at t=15
    b1 = rand_block();
    b_data_in = b1;
    b_data_in_last = 1'b1;
    b_data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_data_in_valid = 1'b0;
    nw = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_data_out_valid) begin
        check(b_data_out == b1[511-32*int'(b_data_out_index) -: 32] &&
              b_data_out_blk_end == (b_data_out_index == 6'd15) &&
              b_data_out_last == (b_data_out_index == 6'd15), "r16_word",
              64'({b_data_out_index, b_data_out_blk_end, b_data_out}),
              64'({6'(nw), nw == 15, b1[511-32*nw -: 32]}));
        nw++;
      end
    end
    check(nw == 16, "r16_count", 64'(nw), 64'd16);

    check(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
